uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: echo FIFO plus message port arbitrated onto one UART transmitter.
// Define UART_TX_ARB_RR_EN for round-robin; the default build is echo-first priority.
module uart_tx_arb #(
  parameter int FIFO_AW = 2
) (
  input  logic       sysclk,
  input  logic       rstn,
  input  logic [7:0] echo_data,
  input  logic       echo_valid,
  output logic       echo_ovf,
  input  logic [7:0] msg_data,
  input  logic       msg_req,
  output logic       msg_ack,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_data_req,
  input  logic       uart_tx_busy,
  input  logic       uart_tx_done,
  output logic       arb_busy
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT
  } state_e;

  state_e state_q, state_d;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;

  logic [7:0] data_q, data_d;
  logic       req_q, req_d;
  logic       ack_q, ack_d;
  logic       ovf_q, ovf_d;

  logic full, empty, push, pop;
  logic echo_pend, any_pend;
  logic grant, grant_echo;

  // Full is judged on the registered count, so a pop this cycle
  // cannot make room for a same-cycle push.
  assign full      = (cnt_q == FULL_CNT);
  assign empty     = (cnt_q == '0);
  assign push      = echo_valid & ~full;
  assign echo_pend = ~empty;
  assign any_pend  = echo_pend | msg_req;

  assign grant = (state_q == S_IDLE) & ~uart_tx_busy & any_pend;
  assign pop   = grant & grant_echo;

`ifdef UART_TX_ARB_RR_EN
  // last_grant_q: 1 = echo granted last, 0 = msg granted last
  logic lg_q, lg_d;

  assign grant_echo = echo_pend & (~msg_req | ~lg_q);
  assign lg_d       = grant ? grant_echo : lg_q;

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) lg_q <= 1'b0;
    else       lg_q <= lg_d;
  end
`else
  assign grant_echo = echo_pend;
`endif

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (push) mem_q[wptr_q] <= echo_data;
  end

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant) state_d = S_SEND;
      S_SEND:  state_d = S_WAIT;
      S_WAIT:  if (uart_tx_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    req_d  = 1'b0;
    ack_d  = 1'b0;
    ovf_d  = echo_valid & full;
    if (grant) begin
      req_d  = 1'b1;
      ack_d  = ~grant_echo;
      data_d = grant_echo ? mem_q[rptr_q] : msg_data;
    end
  end

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      data_q <= 8'h00;
      req_q  <= 1'b0;
      ack_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      req_q  <= req_d;
      ack_q  <= ack_d;
      ovf_q  <= ovf_d;
    end
  end

  assign uart_tx_data     = data_q;
  assign uart_tx_data_req = req_q;
  assign msg_ack          = ack_q;
  assign echo_ovf         = ovf_q;
  assign arb_busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a 20-cycle transmitter model.
// Expected grant order follows UART_TX_ARB_RR_EN when it is defined.
module tb_uart_tx_arb;

  logic       sysclk = 1'b0;
  logic       rstn;
  logic [7:0] echo_data;
  logic       echo_valid;
  logic       echo_ovf;
  logic [7:0] msg_data;
  logic       msg_req;
  logic       msg_ack;
  logic [7:0] uart_tx_data;
  logic       uart_tx_data_req;
  logic       uart_tx_busy;
  logic       uart_tx_done;
  logic       arb_busy;

  logic busy_m;
  logic force_busy;

  int n_vec = 0;
  int n_err = 0;
  int ovf_cnt = 0;
  int ack_cnt = 0;
  logic [7:0] log_q [$];

  assign uart_tx_busy = busy_m | force_busy;

  uart_tx_arb #(.FIFO_AW(2)) dut (
    .sysclk           (sysclk),
    .rstn             (rstn),
    .echo_data        (echo_data),
    .echo_valid       (echo_valid),
    .echo_ovf         (echo_ovf),
    .msg_data         (msg_data),
    .msg_req          (msg_req),
    .msg_ack          (msg_ack),
    .uart_tx_data     (uart_tx_data),
    .uart_tx_data_req (uart_tx_data_req),
    .uart_tx_busy     (uart_tx_busy),
    .uart_tx_done     (uart_tx_done),
    .arb_busy         (arb_busy)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #2;
  endtask

  // transmitter: busy for 20 cycles after each request, then done
  initial begin
    busy_m = 1'b0;
    uart_tx_done = 1'b0;
    forever begin
      @(posedge sysclk);
      #1;
      if (uart_tx_data_req === 1'b1) begin
        busy_m = 1'b1;
        repeat (19) @(posedge sysclk);
        #1 uart_tx_done = 1'b1;
        @(posedge sysclk);
        #1;
        uart_tx_done = 1'b0;
        busy_m = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge sysclk);
      #1;
      if (uart_tx_data_req === 1'b1) log_q.push_back(uart_tx_data);
      if (echo_ovf === 1'b1) ovf_cnt++;
      if (msg_ack === 1'b1) ack_cnt++;
    end
  end

  task automatic wait_log(input int n, input int lim, input string tag);
    int k = 0;
    while (log_q.size() < n && k < lim) begin
      tick();
      k++;
    end
    if (log_q.size() < n) chk({tag, "_timeout"}, log_q.size(), n);
  endtask

  task automatic wait_quiet(input string tag);
    int k = 0;
    while ((arb_busy !== 1'b0 || busy_m !== 1'b0) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) chk({tag, "_quiet_timeout"}, arb_busy, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_data"}, uart_tx_data, 8'h00);
    chk({tag, "_req"},  uart_tx_data_req, 0);
    chk({tag, "_ack"},  msg_ack, 0);
    chk({tag, "_ovf"},  echo_ovf, 0);
    chk({tag, "_busy"}, arb_busy, 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge sysclk);
    #3 rstn = 1'b0;
    #1 chk_reset_outs(tag);
    @(posedge sysclk);
    #3 rstn = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp3 [3];
  logic [7:0] exp4 [4];
  logic [7:0] exp5 [6];
  int mi;
  int k;
  int n0;
  int a0;

  initial begin
    exp3 = '{8'h10, 8'h11, 8'h12};
    exp4 = '{8'h20, 8'h21, 8'h22, 8'h23};
`ifdef UART_TX_ARB_RR_EN
    exp5 = '{8'h30, 8'h40, 8'h31, 8'h41, 8'h32, 8'h42};
`else
    exp5 = '{8'h30, 8'h31, 8'h32, 8'h40, 8'h41, 8'h42};
`endif
    rstn       = 1'b0;
    echo_data  = 8'h00;
    echo_valid = 1'b0;
    msg_data   = 8'h00;
    msg_req    = 1'b0;
    force_busy = 1'b0;
    repeat (3) tick();
    chk_reset_outs("rst");
    rstn = 1'b1;
    repeat (2) tick();
    chk_reset_outs("post_rst");

    // single message byte
    ack_cnt = 0;
    log_q.delete();
    msg_data = 8'h41;
    msg_req  = 1'b1;
    tick();
    chk("msg_req1", uart_tx_data_req, 1);
    chk("msg_ack1", msg_ack, 1);
    chk("msg_data", uart_tx_data, 8'h41);
    chk("msg_busy1", arb_busy, 1);
    msg_req = 1'b0;
    tick();
    chk("msg_req2", uart_tx_data_req, 0);
    chk("msg_ack2", msg_ack, 0);
    chk("msg_busy2", arb_busy, 1);
    repeat (10) tick();
    chk("msg_busy_hold", arb_busy, 1);
    chk("msg_data_hold", uart_tx_data, 8'h41);
    wait_quiet("msg");
    chk("msg_idle", arb_busy, 0);
    chk("msg_acks", ack_cnt, 1);
    chk("msg_nreq", log_q.size(), 1);

    // three back-to-back echo bytes
    log_q.delete();
    ovf_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      echo_data  = 8'h10 + 8'(i);
      echo_valid = 1'b1;
      tick();
      if (i == 1) begin
        chk("echo_lat_req", uart_tx_data_req, 1);
        chk("echo_lat_data", uart_tx_data, 8'h10);
      end
    end
    echo_valid = 1'b0;
    wait_log(3, 300, "echo3");
    wait_quiet("echo3");
    chk("echo3_n", log_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < log_q.size()) chk($sformatf("echo3_b%0d", i), log_q[i], exp3[i]);
    chk("echo3_ovf", ovf_cnt, 0);

    // overflow with the transmitter held busy
    log_q.delete();
    ovf_cnt = 0;
    force_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      echo_data  = 8'h20 + 8'(i);
      echo_valid = 1'b1;
      tick();
    end
    echo_valid = 1'b0;
    repeat (3) tick();
    chk("ovf_cnt", ovf_cnt, 2);
    chk("ovf_noreq", log_q.size(), 0);
    chk("ovf_pulse_low", echo_ovf, 0);
    force_busy = 1'b0;
    wait_log(4, 400, "ovf");
    wait_quiet("ovf");
    repeat (10) tick();
    chk("ovf_n", log_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < log_q.size()) chk($sformatf("ovf_b%0d", i), log_q[i], exp4[i]);

    // arbitration between three echo bytes and three msg bytes
    do_reset("arb_rst");
    log_q.delete();
    ack_cnt = 0;
    force_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      echo_data  = 8'h30 + 8'(i);
      echo_valid = 1'b1;
      tick();
    end
    echo_valid = 1'b0;
    mi = 0;
    msg_data = 8'h40;
    msg_req  = 1'b1;
    tick();
    force_busy = 1'b0;
    k = 0;
    while (log_q.size() < 6 && k < 600) begin
      tick();
      if (msg_ack === 1'b1) begin
        mi++;
        if (mi == 3) msg_req = 1'b0;
        else msg_data = 8'h40 + 8'(mi);
      end
      k++;
    end
    if (log_q.size() < 6) chk("arb_timeout", log_q.size(), 6);
    msg_req = 1'b0;
    wait_quiet("arb");
    chk("arb_n", log_q.size(), 6);
    chk("arb_acks", ack_cnt, 3);
    for (int i = 0; i < 6; i++)
      if (i < log_q.size()) chk($sformatf("arb_g%0d", i), log_q[i], exp5[i]);

    // reset during WAIT with two echo bytes queued
    ack_cnt = 0;
    msg_data = 8'h55;
    msg_req  = 1'b1;
    tick();
    chk("wr_req", uart_tx_data_req, 1);
    msg_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      echo_data  = 8'h60 + 8'(i);
      echo_valid = 1'b1;
      tick();
    end
    echo_valid = 1'b0;
    repeat (3) tick();
    chk("wr_in_wait", arb_busy, 1);
    n0 = log_q.size();
    a0 = ack_cnt;
    do_reset("wr_rst");
    repeat (40) tick();
    chk("wr_noreq", log_q.size(), n0);
    chk("wr_noack", ack_cnt, a0);
    chk("wr_idle", arb_busy, 0);
    chk("wr_data", uart_tx_data, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
